// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN image loader.
package cnn_pkg;

    localparam int PIXEL_W    = 8;
    localparam int IMG_ROWS   = 28;
    localparam int IMG_COLS   = 28;
    localparam int NUM_PIXELS = IMG_ROWS * IMG_COLS;
    localparam int IMG_W      = PIXEL_W * NUM_PIXELS;

    // FILL: collecting pixels; DROP: image ready, discarding overlong tail;
    // HOLD: image presented and stalled until acknowledged.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } loader_state_t;

endpackage

// File: rtl/cnn_image_loader.sv
// Assembles a byte-wide pixel stream into one flattened 28x28 image and
// holds it with image_valid until the consumer acknowledges it. Frames of
// the wrong length raise a one-cycle frame_err pulse.
module cnn_image_loader
    import cnn_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic [PIXEL_W-1:0]   s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [IMG_W-1:0]     input_image,
    output logic                 image_valid,
    input  logic                 img_ack,
    output logic                 frame_err,
    output logic [15:0]          frames_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             image_valid_q, image_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      frames_done_q, frames_done_d;
    logic             s_ready_q, s_ready_d;
    logic             ack_pend_q, ack_pend_d;
    logic [IMG_W-1:0] img_q;
    logic             xfer_s;
    logic             wr_en_s;

    assign xfer_s      = s_valid && s_ready_q;
    assign s_ready     = s_ready_q;
    assign input_image = img_q;
    assign image_valid = image_valid_q;
    assign frame_err   = frame_err_q;
    assign frames_done = frames_done_q;

    // Next-state logic: frame length tracking, delivery and acknowledge handling.
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        image_valid_d = image_valid_q;
        frame_err_d   = 1'b0;
        frames_done_d = frames_done_q;
        ack_pend_d    = ack_pend_q;
        wr_en_s       = 1'b0;
        case (state_q)
            FILL: begin
                if (xfer_s) begin
                    wr_en_s = 1'b1;
                    if (pix_cnt_q == LAST_IDX) begin
                        // Image complete; an overlong frame is still delivered.
                        pix_cnt_d     = {CNT_W{1'b0}};
                        image_valid_d = 1'b1;
                        frames_done_d = frames_done_q + 16'd1;
                        ack_pend_d    = 1'b0;
                        if (s_last) begin
                            state_d = HOLD;
                        end else begin
                            state_d     = DROP;
                            frame_err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        // Short frame: restart; stale slots get overwritten later.
                        pix_cnt_d   = {CNT_W{1'b0}};
                        frame_err_d = 1'b1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            DROP: begin
                // An early acknowledge is remembered and applied once HOLD is reached.
                ack_pend_d = ack_pend_q | img_ack;
                if (xfer_s && s_last) begin
                    state_d = HOLD;
                end else begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (img_ack || ack_pend_q) begin
                    state_d       = FILL;
                    image_valid_d = 1'b0;
                    ack_pend_d    = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d       = FILL;
                pix_cnt_d     = {CNT_W{1'b0}};
                image_valid_d = 1'b0;
                ack_pend_d    = 1'b0;
            end
        endcase
        s_ready_d = (state_d != HOLD);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            pix_cnt_q     <= {CNT_W{1'b0}};
            image_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frames_done_q <= 16'd0;
            s_ready_q     <= 1'b1;
            ack_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            image_valid_q <= image_valid_d;
            frame_err_q   <= frame_err_d;
            frames_done_q <= frames_done_d;
            s_ready_q     <= s_ready_d;
            ack_pend_q    <= ack_pend_d;
        end
    end

    // Image storage: one-hot slot write selected by the pixel counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q <= {IMG_W{1'b0}};
        end else begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                if (wr_en_s && (pix_cnt_q == CNT_W'(i))) begin
                    img_q[i*PIXEL_W +: PIXEL_W] <= s_data;
                end
            end
        end
    end

endmodule
